// File: rtl/misc_exec_unit.sv
// misc_exec_unit: execution unit for the misc issue slot (NOP, HALT, IN, OUT,
// RXCNT). A TX byte FIFO decouples OUT from the UART transmitter and an RX
// byte FIFO buffers received bytes until IN or RXCNT consume them.
//
// Handshakes: a byte moves across tx_* or rx_* in exactly the cycle where
// valid and ready are both high at the rising clock edge. The producer holds
// data stable while valid is high and not yet accepted. issue is accepted
// only when busy==0 and halted==0; completed pulses for one cycle and out
// holds the result from that cycle on.
module misc_exec_unit #(
    parameter int DATA_W   = 32,
    parameter int IO_W     = 8,
    parameter int OP_W     = 6,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [OP_W-1:0]   inst_num,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rd,
    output logic              busy,
    output logic              completed,
    output logic [DATA_W-1:0] out,
    output logic              halted,
    output logic [IO_W-1:0]   tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [IO_W-1:0]   rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [2:0]        dbg_state
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXEC    = 3'd1;
    localparam logic [2:0] S_WAIT_TX = 3'd2;
    localparam logic [2:0] S_WAIT_RX = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_IN    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_OUT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_RXCNT = OP_W'(8);

    logic [2:0]             state_q, state_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [IO_W-1:0]        rs_q, rs_d;
    logic [DATA_W-IO_W-1:0] rd_q, rd_d;
    logic                   completed_q, completed_d;
    logic [DATA_W-1:0]      out_q, out_d;
    logic                   halted_q, halted_d;

    logic [IO_W-1:0]  tx_mem_q [TX_DEPTH];
    logic [IO_W-1:0]  tx_mem_d [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [IO_W-1:0]  rx_mem_q [RX_DEPTH];
    logic [IO_W-1:0]  rx_mem_d [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;

    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_full, rx_empty;
    logic unused_ok;

    // pc is only carried through the slot; the unsent/unmerged operand bits are dropped
    assign unused_ok = ^{pc, rs[DATA_W-1:IO_W], rd[IO_W-1:0]};

    assign tx_full   = (tx_cnt_q == TX_CW'(TX_DEPTH));
    assign rx_empty  = (rx_cnt_q == '0);
    assign busy      = completed_q || (state_q == S_EXEC) ||
                       (state_q == S_WAIT_TX) || (state_q == S_WAIT_RX);
    assign completed = completed_q;
    assign out       = out_q;
    assign halted    = halted_q;
    assign dbg_state = state_q;
    assign tx_data   = tx_mem_q[tx_rd_q];
    // Reset forces the UART-facing flags to their idle values immediately
    assign tx_valid  = !reset && (tx_cnt_q != '0);
    assign rx_ready  = reset || (rx_cnt_q != RX_CW'(RX_DEPTH));
    assign tx_pop    = tx_valid && tx_ready;
    assign rx_push   = rx_valid && rx_ready;

    // Op sequencing: accept, execute or retry, then pulse completed
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs_d        = rs_q;
        rd_d        = rd_q;
        out_d       = out_q;
        halted_d    = halted_q;
        completed_d = 1'b0;
        tx_push     = 1'b0;
        rx_pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue && !busy) begin
                    state_d = S_EXEC;
                    op_d    = inst_num;
                    rs_d    = rs[IO_W-1:0];
                    rd_d    = rd[DATA_W-1:IO_W];
                end
            end
            S_EXEC, S_WAIT_TX, S_WAIT_RX: begin
                case (op_q)
                    OP_HALT: begin
                        out_d       = '1;
                        halted_d    = 1'b1;
                        completed_d = 1'b1;
                        state_d     = S_HALTED;
                    end
                    OP_OUT: begin
                        if (!tx_full) begin
                            tx_push     = 1'b1;
                            completed_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_WAIT_TX;
                        end
                    end
                    OP_IN: begin
                        if (!rx_empty) begin
                            rx_pop      = 1'b1;
                            out_d       = {rd_q, rx_mem_q[rx_rd_q]};
                            completed_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_WAIT_RX;
                        end
                    end
                    OP_RXCNT: begin
                        out_d       = DATA_W'(rx_cnt_q);
                        completed_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                    OP_NOP: begin
                        completed_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                    default: begin
                        completed_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                endcase
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping: push and pop may both happen in one cycle
    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = rs_q;
            tx_wr_d           = tx_wr_q + 1'b1;
        end
        if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_data;
            rx_wr_d           = rx_wr_q + 1'b1;
        end
        if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
        tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
    end

    // Control and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rs_q        <= '0;
            rd_q        <= '0;
            completed_q <= 1'b0;
            out_q       <= '0;
            halted_q    <= 1'b0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs_q        <= rs_d;
            rd_q        <= rd_d;
            completed_q <= completed_d;
            out_q       <= out_d;
            halted_q    <= halted_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // FIFO storage; contents are meaningless once the counters are cleared
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end
endmodule
